// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch stage with prefetch buffer
// Optional fetch performance counter enabled by defining IFU_PERF_CNT_EN.
module instr_fetch_unit #(
   parameter int          ADDR_W   = 9,
   parameter int          DEPTH    = 2,
   parameter int unsigned RESET_PC = 0
) (
   input  logic              clk,
   input  logic              Reset,
   input  logic              Stop,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_read,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ready,
   output logic [31:0]       ir,
   output logic [ADDR_W-1:0] ir_pc,
   output logic              ir_valid,
   input  logic              ir_ack,
   input  logic              pc_load,
   input  logic [ADDR_W-1:0] pc_load_value,
   output logic              halted,
   output logic [31:0]       fetch_count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEPTH);

   typedef enum logic [1:0] {IDLE, REQ, FLUSH} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] fetch_pc;
   logic [ADDR_W-1:0] flush_addr;
   logic [PTR_W-1:0]  head, tail;
   logic [CNT_W-1:0]  count, count_post;
   logic [31:0]       buf_data [DEPTH];
   logic [ADDR_W-1:0] buf_pc   [DEPTH];
   logic              push, pop;

   // A redirect discards both the completing word and any pop in that cycle.
   assign push       = (state == REQ) && mem_ready && !pc_load;
   assign pop        = ir_ack && (count != '0) && !pc_load;
   assign count_post = count + CNT_W'(push) - CNT_W'(pop);

   always_ff @(posedge clk) begin
      if (Reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (!pc_load && (count < CNT_MAX) && !Stop) state_nxt = REQ;
         end
         REQ: begin
            if (pc_load)        state_nxt = mem_ready ? IDLE : FLUSH;
            else if (mem_ready) state_nxt = ((count_post < CNT_MAX) && !Stop) ? REQ : IDLE;
         end
         FLUSH: begin
            if (mem_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      mem_read = (state != IDLE);
      mem_addr = (state == FLUSH) ? flush_addr : fetch_pc;
      halted   = Stop && (state == IDLE);
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         fetch_pc   <= PC_INIT;
         flush_addr <= PC_INIT;
         head       <= '0;
         tail       <= '0;
         count      <= '0;
      end else if (pc_load) begin
         fetch_pc <= pc_load_value;
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         // Only an abort from REQ captures the address still on the bus.
         if (state == REQ) flush_addr <= fetch_pc;
      end else begin
         if (push) begin
            tail     <= tail + PTR_W'(1);
            fetch_pc <= fetch_pc + ADDR_W'(1);
         end
         if (pop) head <= head + PTR_W'(1);
         count <= count_post;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         buf_data[tail] <= mem_rdata;
         buf_pc[tail]   <= fetch_pc;
      end
   end

   assign ir_valid = (count != '0);
   assign ir       = ir_valid ? buf_data[head] : 32'd0;
   assign ir_pc    = ir_valid ? buf_pc[head] : '0;

`ifdef IFU_PERF_CNT_EN
   logic [31:0] perf_q;

   always_ff @(posedge clk) begin
      if (Reset)                       perf_q <= '0;
      else if (push && (perf_q != '1)) perf_q <= perf_q + 32'd1;
   end

   assign fetch_count = perf_q;
`else
   assign fetch_count = 32'd0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit
// Checks fetch_count against IFU_PERF_CNT_EN when defined.
module tb_instr_fetch_unit;

   localparam int ADDR_W = 9;
`ifdef IFU_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              Reset, Stop;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_read;
   logic [31:0]       mem_rdata;
   logic              mem_ready;
   logic [31:0]       ir;
   logic [ADDR_W-1:0] ir_pc;
   logic              ir_valid;
   logic              ir_ack;
   logic              pc_load;
   logic [ADDR_W-1:0] pc_load_value;
   logic              halted;
   logic [31:0]       fetch_count;

   logic [31:0] ram [512];
   int          ram_delay = 0;
   int          wait_cnt  = 0;
   int          rd_cnt    = 0;
   int          checks    = 0;
   int          errors    = 0;

   instr_fetch_unit #(.ADDR_W(ADDR_W), .DEPTH(2), .RESET_PC(0)) dut (
      .clk(clk), .Reset(Reset), .Stop(Stop),
      .mem_addr(mem_addr), .mem_read(mem_read), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ack(ir_ack),
      .pc_load(pc_load), .pc_load_value(pc_load_value),
      .halted(halted), .fetch_count(fetch_count)
   );

   always #5 clk = ~clk;

   // RAM model: ready after ram_delay cycles of a held request
   assign mem_ready = mem_read && (wait_cnt >= ram_delay);
   assign mem_rdata = ram[mem_addr];

   always @(posedge clk) begin
      if (!mem_read || mem_ready) wait_cnt <= 0;
      else                        wait_cnt <= wait_cnt + 1;
      if (mem_read && mem_ready)  rd_cnt <= rd_cnt + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_mem_read"}, 32'(mem_read), 32'd0);
      check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
      check({tag, "_ir"}, ir, 32'd0);
      check({tag, "_ir_pc"}, 32'(ir_pc), 32'd0);
      check({tag, "_ir_valid"}, 32'(ir_valid), 32'd0);
      check({tag, "_halted"}, 32'(halted), 32'd0);
      check({tag, "_fetch_count"}, fetch_count, 32'd0);
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      tick();
      tick();
      Reset = 1'b0;
   endtask

   task automatic wait_valid(input string tag);
      int n = 0;
      while (!ir_valid && n < 30) begin
         tick();
         n++;
      end
      check(tag, 32'(ir_valid), 32'd1);
   endtask

   logic [ADDR_W-1:0] exp_pc;
   logic [ADDR_W-1:0] pv;
   logic [ADDR_W-1:0] wrap_pc [3];
   logic              ack, pl, st;
   int                pops;

   initial begin
      for (int i = 0; i < 512; i++) ram[i] = $urandom;
      ram[0] = 32'h0880_0002;
      ram[1] = 32'h0000_0000;
      Stop = 1'b0; ir_ack = 1'b0; pc_load = 1'b0; pc_load_value = '0; Reset = 1'b1;

      // Reset state, then zero-wait latency
      tick();
      tick();
      check_reset("rst");
      Reset = 1'b0;
      rd_cnt = 0;
      tick();
      check("lat_e1_valid", 32'(ir_valid), 32'd0);
      check("lat_e1_read", 32'(mem_read), 32'd1);
      tick();
      check("lat_e2_valid", 32'(ir_valid), 32'd1);
      check("lat_e2_ir", ir, 32'h0880_0002);
      check("lat_e2_pc", 32'(ir_pc), 32'd0);

      // No ack: buffer fills with exactly DEPTH reads
      for (int i = 0; i < 10; i++) tick();
      check("full_reads", 32'(rd_cnt), 32'd2);
      check("full_mem_read", 32'(mem_read), 32'd0);
      check("full_head_pc", 32'(ir_pc), 32'd0);
      check("full_fetch_count", fetch_count, PERF ? 32'd2 : 32'd0);
      ir_ack = 1'b1;
      tick();
      ir_ack = 1'b0;
      check("ack_pc", 32'(ir_pc), 32'd1);
      check("ack_ir", ir, 32'd0);
      tick();
      check("refill_read", 32'(mem_read), 32'd1);
      check("refill_addr", 32'(mem_addr), 32'd2);
      tick();
      check("refill_reads", 32'(rd_cnt), 32'd3);
      check("refill_idle", 32'(mem_read), 32'd0);

      // Reset with a full buffer
      Reset = 1'b1;
      tick();
      check_reset("rst_full");

      // Redirect during a slow read enters FLUSH
      ram_delay = 3;
      Reset = 1'b0;
      tick();
      tick();
      pc_load = 1'b1; pc_load_value = 9'h040;
      tick();
      pc_load = 1'b0;
      check("flush_read", 32'(mem_read), 32'd1);
      check("flush_addr", 32'(mem_addr), 32'd0);
      check("flush_valid", 32'(ir_valid), 32'd0);
      tick();
      check("flush_addr_hold", 32'(mem_addr), 32'd0);
      check("flush_valid2", 32'(ir_valid), 32'd0);
      tick();
      check("flush_done_valid", 32'(ir_valid), 32'd0);
      wait_valid("flush_new_valid");
      check("flush_new_pc", 32'(ir_pc), 32'h040);
      check("flush_new_ir", ir, ram[9'h040]);

      // Reset in FLUSH
      do_reset();
      tick();
      tick();
      pc_load = 1'b1; pc_load_value = 9'h100;
      tick();
      pc_load = 1'b0;
      check("rstf_in_flush", 32'(mem_read), 32'd1);
      Reset = 1'b1;
      tick();
      check_reset("rst_flush");
      Reset = 1'b0;

      // PC wrap 511 -> 0 -> 1
      ram_delay = 0;
      do_reset();
      pc_load = 1'b1; pc_load_value = 9'd511;
      tick();
      pc_load = 1'b0;
      wrap_pc[0] = 9'd511; wrap_pc[1] = 9'd0; wrap_pc[2] = 9'd1;
      for (int i = 0; i < 3; i++) begin
         wait_valid("wrap_valid");
         check("wrap_pc", 32'(ir_pc), 32'(wrap_pc[i]));
         check("wrap_ir", ir, ram[wrap_pc[i]]);
         ir_ack = 1'b1;
         tick();
         ir_ack = 1'b0;
      end

      // Stop during an outstanding 2-cycle read
      ram_delay = 2;
      do_reset();
      tick();
      Stop = 1'b1;
      tick();
      check("stop_read_held", 32'(mem_read), 32'd1);
      check("stop_not_halted", 32'(halted), 32'd0);
      tick();
      tick();
      check("stop_buffered", 32'(ir_valid), 32'd1);
      check("stop_buffered_pc", 32'(ir_pc), 32'd0);
      check("stop_no_read", 32'(mem_read), 32'd0);
      check("stop_halted", 32'(halted), 32'd1);
      tick();
      tick();
      check("stop_still_idle", 32'(mem_read), 32'd0);
      Stop = 1'b0;
      tick();
      check("resume_read", 32'(mem_read), 32'd1);
      check("resume_addr", 32'(mem_addr), 32'd1);

      // Randomized run against a stream model: pops follow consecutive PCs from the last redirect
      for (int seg = 0; seg < 2; seg++) begin
         ram_delay = seg * 2;
         do_reset();
         exp_pc = '0;
         pops = 0;
         for (int c = 0; c < 1000; c++) begin
            ack = 1'($urandom_range(0, 1));
            pl  = ($urandom_range(0, 29) == 0);
            st  = ($urandom_range(0, 15) == 0);
            pv  = ADDR_W'($urandom);
            if (ir_valid) check("rand_ir_data", ir, ram[ir_pc]);
            else          check("rand_ir_empty", ir, 32'd0);
            if (halted) check("rand_halt_noread", 32'(mem_read), 32'd0);
            if (pl) begin
               exp_pc = pv;
            end else if (ack && ir_valid) begin
               check("rand_pop_pc", 32'(ir_pc), 32'(exp_pc));
               exp_pc = exp_pc + 1'b1;
               pops++;
            end
            ir_ack = ack; pc_load = pl; pc_load_value = pv; Stop = st;
            tick();
            ir_ack = 1'b0; pc_load = 1'b0; Stop = 1'b0;
            if (pl) check("rand_redirect_empty", 32'(ir_valid), 32'd0);
         end
         check("rand_progress", 32'(pops > 50), 32'd1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
